multiplexer_nto1_seq: RTL and testbench
=======================================

Name: multiplexer_nto1_seq

Overview:
Parametrised, registered N-to-1 signed multiplexer that succeeds the fixed 4:1 combinational mux in the LSTM datapath.
- Direct mode: one channel is selected by index and registered out with a valid flag.
- Sequence mode: a single start pulse walks all N channels in order, one per cycle, so gate and state vectors (i, f, o, g, c, h) can share one downstream MAC or activation unit.
- Stall input and last-beat flag let it sit inside the backprop pipeline.

Parameters:
- WIDTH, 32, bit width of each signed channel.
- N_IN, 4, number of input channels (≥2).
- SEL_W, 2, index width; must satisfy 2**SEL_W ≥ N_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- i_data  input  N_IN*WIDTH  packed signed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- i_sel  input  SEL_W  direct-mode channel index.
- i_valid  input  1  direct-mode request.
- i_start  input  1  begin a sequence pass.
- i_stall  input  1  freeze sequence progress.
- o_data  output  WIDTH  registered signed selected channel.
- o_valid  output  1  o_data is new this cycle.
- o_idx  output  SEL_W  channel index carried by o_data.
- o_last  output  1  final beat of a sequence pass.
- o_busy  output  1  sequence pass in progress.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - o_data=0, o_valid=0, o_idx=0, o_last=0, o_busy=0.
  - FSM goes to IDLE and the counter clears.
  - A reset mid-sequence aborts the pass with no o_last.
- FSM states: IDLE and SEQ.
- IDLE:
  - i_start=1 → SEQ with cnt=0. i_start has priority over i_valid; a coincident i_valid is dropped.
  - Else if i_valid=1, the next cycle gives o_data = channel i_sel, o_idx=i_sel, o_valid=1. Latency is 1 cycle.
  - If i_sel ≥ N_IN, o_data=0 with o_valid=1 and o_idx=i_sel.
  - Otherwise o_valid=0 and o_data holds its last value.
- SEQ, each cycle with i_stall=0:
  - o_data = channel cnt from the live i_data, o_idx=cnt, o_valid=1, o_busy=1.
  - o_last=1 when cnt=N_IN-1. cnt increments.
  - After the cnt=N_IN-1 beat, return to IDLE.
- SEQ, cycle with i_stall=1:
  - cnt holds; o_valid=0, o_last=0; o_data and o_idx hold; o_busy stays 1.
- Timing: i_start seen at edge t gives beats at edges t+1 … t+N_IN when unstalled. o_busy is high on exactly those cycles.
- In SEQ, i_start and i_valid are ignored, except as below.
- Back-to-back: i_start=1 during the o_last cycle (last beat being presented) re-enters SEQ with cnt=0. The next pass follows with no bubble.
- o_valid, o_last and o_busy are registered outputs. No combinational path from inputs to outputs.
- Data is passed unmodified, with no sign or width change.

Optional Feature:
Macro MUXN_SNAPSHOT_EN.
- Defined: on an accepted i_start, all N_IN channels are captured into an internal N_IN*WIDTH register. Sequence beats read the snapshot, so i_data may change during the pass. Direct mode still reads live i_data.
- Not defined: no snapshot register; sequence beats read live i_data each cycle, and the upstream must hold i_data stable while o_busy=1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_valid=1 and i_start=1 → all outputs 0; release → outputs remain 0 until a new request.
- Direct mode: WIDTH=32, N_IN=4, channels {-5, 7, 0x7FFFFFFF, 0x80000000}, i_sel=3, i_valid pulse → one cycle later o_data=0x80000000, o_idx=3, o_valid=1 for exactly 1 cycle.
- Out-of-range select: N_IN=3, SEL_W=2, i_sel=3, i_valid=1 → o_data=0, o_valid=1, o_idx=3.
- Sequence with stall: i_start at cycle 0, i_stall=1 at cycle 2 only → beats idx 0,1 at cycles 1,2, a frozen cycle at 3 with o_valid=0, then idx 2,3 at cycles 4,5. o_last=1 only at cycle 5; o_busy=1 on cycles 1–5.
- Back-to-back and priority:
  - i_start asserted on the o_last cycle → next cycle o_idx=0, o_valid=1, no gap.
  - i_start and i_valid together in IDLE → sequence runs and the direct request is dropped.
- Snapshot: pass run twice, once with MUXN_SNAPSHOT_EN defined and once without; i_data is changed to all 0x11111111 after i_start.
  - Defined: beats carry the original values.
  - Not defined: beats 1 onward carry 0x11111111.
  - Reset asserted at beat 2 → o_busy=0 next cycle, no o_last.

Source files
------------

// File: rtl/multiplexer_nto1_seq.sv
// multiplexer_nto1_seq
// Registered N-to-1 signed multiplexer with two modes:
//   direct   : i_valid picks channel i_sel, registered out one cycle later
//   sequence : i_start walks channels 0..N_IN-1, one beat per unstalled cycle
// Optional macro MUXN_SNAPSHOT_EN: when defined, every accepted i_start
// captures all channels so the upstream may change i_data during a pass.
// When it is not defined, sequence beats read the live i_data.

module multiplexer_nto1_seq #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_IN*WIDTH-1:0]   i_data,
   input  logic [SEL_W-1:0]        i_sel,
   input  logic                    i_valid,
   input  logic                    i_start,
   input  logic                    i_stall,
   output logic [WIDTH-1:0]        o_data,
   output logic                    o_valid,
   output logic [SEL_W-1:0]        o_idx,
   output logic                    o_last,
   output logic                    o_busy
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEQ  = 1'b1;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

   logic                  state;
   logic [SEL_W-1:0]      cnt;
   logic [N_IN*WIDTH-1:0] seq_src;
   logic [WIDTH-1:0]      direct_data;
   logic [WIDTH-1:0]      seq_data;

   // Out-of-range indices select nothing and therefore yield zero.
   function automatic logic [WIDTH-1:0] pick(
      input logic [N_IN*WIDTH-1:0] bus,
      input logic [SEL_W-1:0]      idx
   );
      logic [WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (int'(idx) == k) begin
            r = bus[k*WIDTH +: WIDTH];
         end
      end
      return r;
   endfunction

`ifdef MUXN_SNAPSHOT_EN
   logic [N_IN*WIDTH-1:0] snap;

   // Capture every channel on an accepted start so the pass is immune to i_data changes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap <= '0;
      end else if (state == ST_IDLE && i_start) begin
         snap <= i_data;
      end
   end

   assign seq_src = snap;
`else
   assign seq_src = i_data;
`endif

   assign direct_data = pick(i_data, i_sel);
   assign seq_data    = pick(seq_src, cnt);

   // Mode FSM plus all registered outputs; start beats direct request in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_idx   <= '0;
         o_last  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_valid <= 1'b0;
               o_last  <= 1'b0;
               o_busy  <= 1'b0;
               if (i_start && o_last && !i_stall) begin
                  // Restart while the previous last beat is on the outputs:
                  // present beat 0 right away so the passes abut without a gap.
                  // Channel 0 comes from live i_data, which equals any fresh snapshot.
                  o_data  <= i_data[WIDTH-1:0];
                  o_idx   <= '0;
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
                  cnt     <= SEL_W'(1);
                  state   <= ST_SEQ;
               end else if (i_start) begin
                  cnt   <= '0;
                  state <= ST_SEQ;
               end else if (i_valid) begin
                  o_data  <= direct_data;
                  o_idx   <= i_sel;
                  o_valid <= 1'b1;
               end
            end
            ST_SEQ: begin
               o_busy <= 1'b1;
               if (i_stall) begin
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
               end else begin
                  o_data  <= seq_data;
                  o_idx   <= cnt;
                  o_valid <= 1'b1;
                  o_last  <= (cnt == LAST_IDX);
                  if (cnt == LAST_IDX) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplexer_nto1_seq.sv
// Testbench for multiplexer_nto1_seq.
// Direct-mode vectors come from a table; sequence passes push their expected
// beats (with the cycle they must appear on) into a scoreboard queue that a
// negedge monitor drains whenever o_valid is high.

module tb_multiplexer_nto1_seq;

   typedef struct {
      logic [1:0]   sel;
      logic [127:0] data;
      logic [31:0]  expData;
   } dirVec_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [1:0]  idx;
      logic        last;
   } sbEntry_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] iData;
   logic [1:0]   iSel;
   logic         iValid, iStart, iStall;
   logic [31:0]  oData;
   logic         oValid, oLast, oBusy;
   logic [1:0]   oIdx;

   logic [95:0]  d3Data;
   logic [1:0]   d3Sel;
   logic         d3Valid;
   logic         d3Start = 1'b0;
   logic         d3Stall = 1'b0;
   logic [31:0]  d3OData;
   logic         d3OValid, d3OLast, d3OBusy;
   logic [1:0]   d3OIdx;

   int           cyc = 0;
   int           nVec = 0;
   int           nMiss = 0;
   sbEntry_t     sbQ[$];
   dirVec_t      vecs[8];
   logic [31:0]  chB[4];
   logic [31:0]  expVal;
   int           s;

   localparam logic [127:0] DATA_A = {32'h80000000, 32'h7FFFFFFF, 32'h00000007, 32'hFFFFFFFB};
   localparam logic [127:0] DATA_B = {32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hDEADBEEF};

   multiplexer_nto1_seq #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_data(iData), .i_sel(iSel),
      .i_valid(iValid), .i_start(iStart), .i_stall(iStall),
      .o_data(oData), .o_valid(oValid), .o_idx(oIdx),
      .o_last(oLast), .o_busy(oBusy)
   );

   multiplexer_nto1_seq #(.WIDTH(32), .N_IN(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .i_data(d3Data), .i_sel(d3Sel),
      .i_valid(d3Valid), .i_start(d3Start), .i_stall(d3Stall),
      .o_data(d3OData), .o_valid(d3OValid), .o_idx(d3OIdx),
      .o_last(d3OLast), .o_busy(d3OBusy)
   );

   // Free-running clock and edge counter used to timestamp expected beats.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Check busy for the current cycle, drive the next cycle's controls, advance.
   task automatic applyStimulus(input logic v, input logic st, input logic sl, input logic expBusy);
      checkOutput("busy", {63'd0, oBusy}, {63'd0, expBusy});
      iValid = v;
      iStart = st;
      iStall = sl;
      @(negedge clk);
   endtask

   task automatic pushBeat(input int c, input logic [31:0] d, input int k, input logic l);
      sbEntry_t e;
      e.cyc  = c;
      e.data = d;
      e.idx  = 2'(k);
      e.last = l;
      sbQ.push_back(e);
   endtask

   // Scoreboard monitor: flags beats that never came, unexpected beats, and wrong contents.
   always @(negedge clk) begin : monBlk
      sbEntry_t e;
      while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
         e = sbQ.pop_front();
         nVec++;
         nMiss++;
         $display("[TB] FAIL missingBeat: idx %0d due cycle %0d absent, expected data %0h", e.idx, e.cyc, e.data);
      end
      if (oValid === 1'b1) begin
         if (sbQ.size() == 0) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL unexpectedBeat at cycle %0d: got data %0h idx %0d, expected no beat", cyc, oData, oIdx);
         end else begin
            e = sbQ.pop_front();
            checkOutput("beatCycle", 64'(cyc), 64'(e.cyc));
            checkOutput("beatData", {32'd0, oData}, {32'd0, e.data});
            checkOutput("beatIdx", {62'd0, oIdx}, {62'd0, e.idx});
            checkOutput("beatLast", {63'd0, oLast}, {63'd0, e.last});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{2'd3, DATA_A, 32'h80000000};
      vecs[1] = '{2'd0, DATA_A, 32'hFFFFFFFB};
      vecs[2] = '{2'd1, DATA_A, 32'h00000007};
      vecs[3] = '{2'd2, DATA_A, 32'h7FFFFFFF};
      vecs[4] = '{2'd0, DATA_B, 32'hDEADBEEF};
      vecs[5] = '{2'd2, DATA_B, 32'h00000000};
      vecs[6] = '{2'd3, DATA_B, 32'hCAFEF00D};
      vecs[7] = '{2'd1, DATA_B, 32'h12345678};
      chB[0] = 32'hDEADBEEF;
      chB[1] = 32'h12345678;
      chB[2] = 32'h00000000;
      chB[3] = 32'hCAFEF00D;

      // Reset held two edges with both requests asserted.
      rst_n   = 1'b0;
      iValid  = 1'b1;
      iStart  = 1'b1;
      iStall  = 1'b0;
      iSel    = 2'd3;
      iData   = DATA_A;
      d3Data  = {32'h7FFFFFFF, 32'h00000007, 32'hFFFFFFFB};
      d3Sel   = 2'd2;
      d3Valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstData", {32'd0, oData}, 64'd0);
      checkOutput("rstValid", {63'd0, oValid}, 64'd0);
      checkOutput("rstIdx", {62'd0, oIdx}, 64'd0);
      checkOutput("rstLast", {63'd0, oLast}, 64'd0);
      checkOutput("rstBusy", {63'd0, oBusy}, 64'd0);
      checkOutput("rstValid3", {63'd0, d3OValid}, 64'd0);
      rst_n   = 1'b1;
      iValid  = 1'b0;
      iStart  = 1'b0;
      d3Valid = 1'b0;
      @(negedge clk);
      checkOutput("postRstValid", {63'd0, oValid}, 64'd0);
      checkOutput("postRstBusy", {63'd0, oBusy}, 64'd0);
      checkOutput("postRstData", {32'd0, oData}, 64'd0);
      applyStimulus(0, 0, 0, 0);

      // Direct-mode table.
      for (int i = 0; i < 8; i++) begin
         iData = vecs[i].data;
         iSel  = vecs[i].sel;
         pushBeat(cyc + 1, vecs[i].expData, int'(vecs[i].sel), 1'b0);
         applyStimulus(1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("holdData", {32'd0, oData}, {32'd0, 32'h12345678});
      checkOutput("holdValid", {63'd0, oValid}, 64'd0);
      checkOutput("holdIdx", {62'd0, oIdx}, 64'd1);

      // Three-channel instance: in-range then out-of-range select.
      d3Sel   = 2'd2;
      d3Valid = 1'b1;
      @(negedge clk);
      checkOutput("n3Sel2Data", {32'd0, d3OData}, {32'd0, 32'h7FFFFFFF});
      d3Sel = 2'd3;
      @(negedge clk);
      checkOutput("n3OorData", {32'd0, d3OData}, 64'd0);
      checkOutput("n3OorValid", {63'd0, d3OValid}, 64'd1);
      checkOutput("n3OorIdx", {62'd0, d3OIdx}, 64'd3);
      checkOutput("n3OorBusy", {63'd0, d3OBusy}, 64'd0);
      checkOutput("n3OorLast", {63'd0, d3OLast}, 64'd0);
      d3Valid = 1'b0;
      @(negedge clk);
      checkOutput("n3Pulse", {63'd0, d3OValid}, 64'd0);

      // Sequence pass with one stalled cycle after beat 1.
      iData = DATA_A;
      s = cyc + 1;
      pushBeat(s + 1, 32'hFFFFFFFB, 0, 1'b0);
      pushBeat(s + 2, 32'h00000007, 1, 1'b0);
      pushBeat(s + 4, 32'h7FFFFFFF, 2, 1'b0);
      pushBeat(s + 5, 32'h80000000, 3, 1'b1);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 1);
      checkOutput("stallValid", {63'd0, oValid}, 64'd0);
      checkOutput("stallLast", {63'd0, oLast}, 64'd0);
      checkOutput("stallIdx", {62'd0, oIdx}, 64'd1);
      checkOutput("stallData", {32'd0, oData}, 64'd7);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);

      // Start+valid together (direct dropped), then restart on the o_last cycle.
      iData = DATA_B;
      iSel  = 2'd2;
      s = cyc + 1;
      for (int k = 0; k < 4; k++) pushBeat(s + 1 + k, chB[k], k, k == 3);
      for (int k = 0; k < 4; k++) pushBeat(s + 5 + k, chB[k], k, k == 3);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);

      // i_data overwritten once beat 0 is out.
      iData = DATA_B;
      s = cyc + 1;
      for (int k = 0; k < 4; k++) begin
`ifdef MUXN_SNAPSHOT_EN
         expVal = chB[k];
`else
         expVal = (k == 0) ? chB[0] : 32'h11111111;
`endif
         pushBeat(s + 1 + k, expVal, k, k == 3);
      end
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      iData = {4{32'h11111111}};
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);

      // Reset arriving where beat 2 would be aborts the pass.
      iData = DATA_A;
      s = cyc + 1;
      pushBeat(s + 1, 32'hFFFFFFFB, 0, 1'b0);
      pushBeat(s + 2, 32'h00000007, 1, 1'b0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 1);
      checkOutput("abortBusy", {63'd0, oBusy}, 64'd0);
      checkOutput("abortLast", {63'd0, oLast}, 64'd0);
      checkOutput("abortValid", {63'd0, oValid}, 64'd0);
      checkOutput("abortData", {32'd0, oData}, 64'd0);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      checkOutput("scoreboardDrained", 64'(sbQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
